serial_subtractor: RTL

Bit-serial, LSB-first ripple-borrow subtractor: computes `diff = a - b - bin` one bit per clock with a single full-subtractor cell and a borrow flip-flop. It is the inverse-operation companion to the team's ripple full adder and trades latency for area. It sits behind a start/busy/done handshake so a controller or self-checking harness can issue operands and collect results.

---
 rtl/serial_subtractor_if.sv | 27 ++
 rtl/serial_subtractor.sv | 120 ++++++++++++
 2 files changed

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor: start/busy/done handshake plus data.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    logic             zero;

    // Controller side: issues operands, collects results.
    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, ovf, zero
    );

    // Subtractor side.
    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, ovf, zero
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first ripple-borrow subtractor: diff = a - b - bin, one bit per clock,
// using a single full-subtractor cell and a borrow flip-flop behind a start/busy/done handshake.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input logic                clk,
    input logic                rst,
    serial_subtractor_if.slave bus
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, b_q, res_q;
    logic               br_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               a_msb_q, b_msb_q;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   diff_q;
    logic               bout_q, ovf_q, zero_q;

    logic               last_bit;
    logic               accept;
    logic               d_bit;
    logic               br_next;
    logic [WIDTH-1:0]   res_next;

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    // New operands are taken from IDLE or straight out of DONE (back-to-back).
    assign accept   = bus.start && ((state_q == StIdle) || (state_q == StDone));

    // Full-subtractor cell on the current LSBs; result fills from the MSB side.
    assign d_bit    = a_q[0] ^ b_q[0] ^ br_q;
    assign br_next  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    assign res_next = {d_bit, res_q[WIDTH-1:1]};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.start) state_d = StRun;
            StRun:   if (last_bit) state_d = StDone;
            StDone:  state_d = bus.start ? StRun : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Handshake outputs decoded from the next state so they can be registered.
    always_comb begin
        busy_d = (state_d == StRun);
        done_d = (state_d == StDone);
    end

    // Registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    // Operand capture, serial datapath and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else if (accept) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            res_q   <= '0;
            br_q    <= bus.bin;
            cnt_q   <= '0;
            // Operand MSBs are shifted out during RUN, so keep them for the overflow test.
            a_msb_q <= bus.a[WIDTH-1];
            b_msb_q <= bus.b[WIDTH-1];
        end else if (state_q == StRun) begin
            a_q   <= a_q >> 1;
            b_q   <= b_q >> 1;
            res_q <= res_next;
            br_q  <= br_next;
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_bit) begin
                diff_q <= res_next;
                bout_q <= br_next;
                ovf_q  <= (a_msb_q != b_msb_q) && (res_next[WIDTH-1] != a_msb_q);
                zero_q <= (res_next == '0);
            end
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
    assign bus.ovf  = ovf_q;
    assign bus.zero = zero_q;
endmodule
